me_frame_sched: RTL and testbench

//  Frame-level scheduler for me_top: walks an MB_COLS x MB_ROWS macroblock grid in raster order.
//  For each block it publishes the block coordinates, runs one 4-phase req/ack search on me_top,
//  and captures min_sad/min_mvec into a valid/ready result register. It also keeps a saturating

---
 rtl/me_frame_sched.sv | 170 +++++++++++++++++
 tb/tb_me_frame_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_frame_sched.sv
// ---------------------------------------------------------------------------
// me_frame_sched
//   Frame-level scheduler for me_top. Walks an MB_COLS x MB_ROWS macroblock
//   grid in raster order. For each block it publishes the block coordinates,
//   runs one 4-phase req/ack search on me_top and captures min_sad/min_mvec
//   into a valid/ready result register. It also keeps a saturating frame SAD
//   total.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, abort          frame control (start sampled only when idle)
//   busy, done            frame status; done is a one-cycle pulse
//   me_req, me_ack        4-phase handshake with me_top
//   me_min_sad/mvec       search result from me_top
//   mb_x, mb_y            current block coordinates
//   res_valid/ready       result register handshake
//   res_sad/mvec/mb_x/y   captured result and the block it belongs to
//   total_sad             saturating sum of captured SADs this frame
// ---------------------------------------------------------------------------
module me_frame_sched #(
    parameter int MB_COLS = 4,
    parameter int MB_ROWS = 3,
    parameter int SAD_W   = 16,
    parameter int MVEC_W  = 12,
    parameter int TOT_W   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              me_req,
    input  logic              me_ack,
    input  logic [SAD_W-1:0]  me_min_sad,
    input  logic [MVEC_W-1:0] me_min_mvec,
    output logic [7:0]        mb_x,
    output logic [7:0]        mb_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SAD_W-1:0]  res_sad,
    output logic [MVEC_W-1:0] res_mvec,
    output logic [7:0]        res_mb_x,
    output logic [7:0]        res_mb_y,
    output logic [TOT_W-1:0]  total_sad
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_REL  = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [7:0] LAST_X = 8'(MB_COLS - 1);
    localparam logic [7:0] LAST_Y = 8'(MB_ROWS - 1);

    // Sum is wide enough for either operand plus a carry, so a SAD wider
    // than the accumulator still clamps correctly instead of wrapping.
    localparam int             SUM_W   = ((SAD_W > TOT_W) ? SAD_W : TOT_W) + 1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    logic [2:0]       state;
    logic             abort_pend;
    logic [SUM_W-1:0] sum_ext;
    logic [TOT_W-1:0] sum_sat;
    logic             consumed;
    logic             last_blk;

    always_comb begin
        sum_ext  = SUM_W'(total_sad) + SUM_W'(me_min_sad);
        sum_sat  = (sum_ext > SUM_W'(TOT_MAX)) ? TOT_MAX : sum_ext[TOT_W-1:0];
        // Result register is free now, or frees on this very edge.
        consumed = !res_valid || res_ready;
        last_blk = (mb_x == LAST_X) && (mb_y == LAST_Y);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            abort_pend <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            me_req     <= 1'b0;
            mb_x       <= '0;
            mb_y       <= '0;
            res_valid  <= 1'b0;
            res_sad    <= '0;
            res_mvec   <= '0;
            res_mb_x   <= '0;
            res_mb_y   <= '0;
            total_sad  <= '0;
        end else begin
            if (res_valid && res_ready)
                res_valid <= 1'b0;

            if (state != S_IDLE && abort)
                abort_pend <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_REQ;
                        busy      <= 1'b1;
                        me_req    <= 1'b1;
                        mb_x      <= '0;
                        mb_y      <= '0;
                        total_sad <= '0;
                    end
                end

                S_REQ: begin
                    if (me_ack) begin
                        res_sad   <= me_min_sad;
                        res_mvec  <= me_min_mvec;
                        res_mb_x  <= mb_x;
                        res_mb_y  <= mb_y;
                        res_valid <= 1'b1;
                        total_sad <= sum_sat;
                        me_req    <= 1'b0;
                        state     <= S_REL;
                    end
                end

                S_REL: begin
                    if (!me_ack)
                        state <= S_HOLD;
                end

                S_HOLD: begin
                    if (consumed) begin
                        // An abort arriving in this same cycle is honoured too.
                        if (abort_pend || abort) begin
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                            abort_pend <= 1'b0;
                        end else if (last_blk) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            if (mb_x == LAST_X) begin
                                mb_x <= '0;
                                mb_y <= mb_y + 8'd1;
                            end else begin
                                mb_x <= mb_x + 8'd1;
                            end
                            me_req <= 1'b1;
                            state  <= S_REQ;
                        end
                    end
                end

                S_DONE: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    abort_pend <= 1'b0;
                    state      <= S_IDLE;
                end

                default: begin
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    me_req     <= 1'b0;
                    abort_pend <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_me_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_me_frame_sched
//   Directed bench for me_frame_sched. Three instances with different
//   geometries share the stimulus; start is steered to the selected one and
//   its outputs are muxed onto one observation bus. Idle instances ignore
//   ack and abort, so sharing those inputs is harmless.
//     u_a : 2x2 grid, TOT_W=24
//     u_b : 2x1 grid, TOT_W=8  (saturation)
//     u_c : 1x1 grid
// ---------------------------------------------------------------------------
module tb_me_frame_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, ack, res_ready;
    logic [15:0] sad;
    logic [11:0] mvec;
    int          sel;

    logic        start_v [3];
    logic        busy_v [3], done_v [3], req_v [3], rv_v [3];
    logic [7:0]  mbx_v [3], mby_v [3], rx_v [3], ry_v [3];
    logic [15:0] rsad_v [3];
    logic [11:0] rmvec_v [3];
    logic [23:0] tot_a, tot_c;
    logic [7:0]  tot_b;

    logic        busy, done, req, rv;
    logic [7:0]  mbx, mby, rx, ry;
    logic [15:0] rsad;
    logic [11:0] rmvec;
    logic [23:0] tot;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int unsigned k = 0; k < 3; k++)
            start_v[k] = start && (sel == int'(k));
    end

    me_frame_sched #(.MB_COLS(2), .MB_ROWS(2), .SAD_W(16), .MVEC_W(12), .TOT_W(24)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort),
        .busy(busy_v[0]), .done(done_v[0]), .me_req(req_v[0]), .me_ack(ack),
        .me_min_sad(sad), .me_min_mvec(mvec), .mb_x(mbx_v[0]), .mb_y(mby_v[0]),
        .res_valid(rv_v[0]), .res_ready(res_ready), .res_sad(rsad_v[0]),
        .res_mvec(rmvec_v[0]), .res_mb_x(rx_v[0]), .res_mb_y(ry_v[0]),
        .total_sad(tot_a));

    me_frame_sched #(.MB_COLS(2), .MB_ROWS(1), .SAD_W(16), .MVEC_W(12), .TOT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort),
        .busy(busy_v[1]), .done(done_v[1]), .me_req(req_v[1]), .me_ack(ack),
        .me_min_sad(sad), .me_min_mvec(mvec), .mb_x(mbx_v[1]), .mb_y(mby_v[1]),
        .res_valid(rv_v[1]), .res_ready(res_ready), .res_sad(rsad_v[1]),
        .res_mvec(rmvec_v[1]), .res_mb_x(rx_v[1]), .res_mb_y(ry_v[1]),
        .total_sad(tot_b));

    me_frame_sched #(.MB_COLS(1), .MB_ROWS(1), .SAD_W(16), .MVEC_W(12), .TOT_W(24)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort),
        .busy(busy_v[2]), .done(done_v[2]), .me_req(req_v[2]), .me_ack(ack),
        .me_min_sad(sad), .me_min_mvec(mvec), .mb_x(mbx_v[2]), .mb_y(mby_v[2]),
        .res_valid(rv_v[2]), .res_ready(res_ready), .res_sad(rsad_v[2]),
        .res_mvec(rmvec_v[2]), .res_mb_x(rx_v[2]), .res_mb_y(ry_v[2]),
        .total_sad(tot_c));

    always_comb begin
        busy  = busy_v[sel];
        done  = done_v[sel];
        req   = req_v[sel];
        rv    = rv_v[sel];
        mbx   = mbx_v[sel];
        mby   = mby_v[sel];
        rx    = rx_v[sel];
        ry    = ry_v[sel];
        rsad  = rsad_v[sel];
        rmvec = rmvec_v[sel];
        case (sel)
            1:       tot = {16'd0, tot_b};
            2:       tot = tot_c;
            default: tot = tot_a;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req();
        int n = 0;
        while (req !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("req_seen", {31'd0, req}, 32'd1);
    endtask

    // me_top model: ack `dly` cycles after req, drop ack once req falls.
    task automatic run_block(input logic [15:0] s, input logic [11:0] mv,
                             input logic [7:0] ex, input logic [7:0] ey,
                             input logic [23:0] et, input int dly);
        wait_req();
        chk("mb_x", {24'd0, mbx}, {24'd0, ex});
        chk("mb_y", {24'd0, mby}, {24'd0, ey});
        step(dly);
        ack  = 1'b1;
        sad  = s;
        mvec = mv;
        step();
        chk("cap_valid", {31'd0, rv}, 32'd1);
        chk("cap_sad", {16'd0, rsad}, {16'd0, s});
        chk("cap_mvec", {20'd0, rmvec}, {20'd0, mv});
        chk("cap_x", {24'd0, rx}, {24'd0, ex});
        chk("cap_y", {24'd0, ry}, {24'd0, ey});
        chk("total", {8'd0, tot}, {8'd0, et});
        chk("req_low", {31'd0, req}, 32'd0);
        ack  = 1'b0;
        sad  = '0;
        mvec = '0;
        step();
    endtask

    task automatic count_pulses(input int n, output int d, output int r);
        d = 0;
        r = 0;
        repeat (n) begin
            step();
            if (done === 1'b1) d++;
            if (req === 1'b1) r++;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("req_after_start", {31'd0, req}, 32'd1);
        chk("total_cleared", {8'd0, tot}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, r, bad;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0;
        sad = '0; mvec = '0; res_ready = 1'b1; sel = 0;
        step(2);

        // Reset state of every instance.
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1;
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_req", {31'd0, req}, 32'd0);
            chk("rst_valid", {31'd0, rv}, 32'd0);
            chk("rst_total", {8'd0, tot}, 32'd0);
            chk("rst_rsad", {16'd0, rsad}, 32'd0);
        end
        sel = 0;
        rst_n = 1'b1;
        step();

        // Full 2x2 frame, res_ready held high, start pulse mid-frame ignored.
        do_start();
        run_block(16'd10, 12'h101, 8'd0, 8'd0, 24'd10, 5);
        run_block(16'd20, 12'h102, 8'd1, 8'd0, 24'd30, 5);
        start = 1'b1;
        step();
        start = 1'b0;
        run_block(16'd30, 12'h103, 8'd0, 8'd1, 24'd60, 5);
        run_block(16'd40, 12'h104, 8'd1, 8'd1, 24'd100, 5);
        count_pulses(10, d, r);
        chk("frame_done_pulses", d, 1);
        chk("frame_no_extra_req", r, 0);
        chk("frame_busy_end", {31'd0, busy}, 32'd0);
        chk("frame_total_hold", {8'd0, tot}, 32'd100);
        chk("frame_mbx_hold", {24'd0, mbx}, 32'd1);
        chk("frame_mby_hold", {24'd0, mby}, 32'd1);

        // Backpressure on block 0, then abort while block 1 waits for ack.
        res_ready = 1'b0;
        do_start();
        run_block(16'd7, 12'h0AB, 8'd0, 8'd0, 24'd7, 2);
        bad = 0;
        repeat (20) begin
            step();
            if (rv !== 1'b1 || rsad !== 16'd7 || rmvec !== 12'h0AB || req !== 1'b0)
                bad++;
        end
        chk("bp_stable_cycles_bad", bad, 0);
        res_ready = 1'b1;
        step();
        chk("bp_accept_valid", {31'd0, rv}, 32'd0);
        chk("bp_next_req", {31'd0, req}, 32'd1);
        chk("bp_next_x", {24'd0, mbx}, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        run_block(16'd9, 12'h0CD, 8'd1, 8'd0, 24'd16, 3);
        count_pulses(15, d, r);
        chk("abort_no_done", d, 0);
        chk("abort_no_req", r, 0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, rv}, 32'd0);

        // Saturation with an 8-bit accumulator.
        sel = 1;
        #1;
        do_start();
        run_block(16'd200, 12'h011, 8'd0, 8'd0, 24'd200, 2);
        run_block(16'd100, 12'h022, 8'd1, 8'd0, 24'd255, 2);
        count_pulses(10, d, r);
        chk("sat_done", d, 1);
        chk("sat_total_hold", {8'd0, tot}, 32'd255);

        // Asynchronous reset while block 1 is in its request phase.
        sel = 0;
        #1;
        res_ready = 1'b0;
        do_start();
        run_block(16'd5, 12'h005, 8'd0, 8'd0, 24'd5, 2);
        res_ready = 1'b1;
        step();
        chk("pre_rst_req", {31'd0, req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, req}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_mbx", {24'd0, mbx}, 32'd0);
        chk("arst_total", {8'd0, tot}, 32'd0);
        chk("arst_rsad", {16'd0, rsad}, 32'd0);
        chk("arst_rx", {24'd0, rx}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        do_start();
        run_block(16'd1, 12'h001, 8'd0, 8'd0, 24'd1, 1);
        run_block(16'd2, 12'h002, 8'd1, 8'd0, 24'd3, 1);
        run_block(16'd3, 12'h003, 8'd0, 8'd1, 24'd6, 1);
        run_block(16'd4, 12'h004, 8'd1, 8'd1, 24'd10, 1);
        count_pulses(10, d, r);
        chk("post_rst_done", d, 1);
        chk("post_rst_total", {8'd0, tot}, 32'd10);

        // 1x1 grid; ack while idle ignored; done one cycle after acceptance.
        sel = 2;
        #1;
        ack = 1'b1;
        step(2);
        ack = 1'b0;
        chk("idle_ack_valid", {31'd0, rv}, 32'd0);
        chk("idle_ack_req", {31'd0, req}, 32'd0);
        res_ready = 1'b0;
        do_start();
        run_block(16'd33, 12'h3C3, 8'd0, 8'd0, 24'd33, 4);
        chk("one_no_done_yet", {31'd0, done}, 32'd0);
        res_ready = 1'b1;
        step();
        chk("one_done", {31'd0, done}, 32'd1);
        chk("one_valid_cleared", {31'd0, rv}, 32'd0);
        step();
        chk("one_done_end", {31'd0, done}, 32'd0);
        chk("one_busy_end", {31'd0, busy}, 32'd0);
        count_pulses(10, d, r);
        chk("one_no_req", r, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
